ar_xbar_router: RTL
===================

Name: ar_xbar_router

Overview:
- Parametrised AXI read-address (AR) channel crossbar: NUM_M masters to NUM_S slaves plus one default (decode-error) slave.
- Round-robin arbitration, mask/base address decode and a one-entry registered output stage.
- Per-master outstanding-read limiting.
- Sits between CPU/DMA masters and the memory/peripheral slaves, paired with the R-channel return path.

Parameters:
- NUM_M, 2, number of masters.
- NUM_S, 5, number of decoded slaves; default slave is index NUM_S.
- ID_W, 4, master-side ARID width.
- IDS_W, ID_W+$clog2(NUM_M), slave-side ARID width.
- ADDR_W, 32, address width.
- LEN_W, 4, ARLEN width.
- SIZE_W, 3, ARSIZE width.
- SLV_BASE, {NUM_S x ADDR_W}, packed slave base addresses; slave i in slice i.
- SLV_MASK, {NUM_S x ADDR_W}, packed slave decode masks.
- MAX_OUT, 4, maximum outstanding reads per master (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- arid_m  in  NUM_M*ID_W  master ARID, master k in slice k.
- araddr_m  in  NUM_M*ADDR_W  master ARADDR.
- arlen_m  in  NUM_M*LEN_W  master ARLEN.
- arsize_m  in  NUM_M*SIZE_W  master ARSIZE.
- arburst_m  in  NUM_M*2  master ARBURST.
- arvalid_m  in  NUM_M  master ARVALID.
- arready_m  out  NUM_M  master ARREADY.
- rdone_m  in  NUM_M  one-cycle pulse per master on the RLAST handshake (from R path).
- arid_s  out  IDS_W  {master index, ARID}, shared by all slaves.
- araddr_s  out  ADDR_W  shared slave address.
- arlen_s  out  LEN_W  shared slave ARLEN.
- arsize_s  out  SIZE_W  shared slave ARSIZE.
- arburst_s  out  2  shared slave ARBURST.
- arvalid_s  out  NUM_S+1  per-slave ARVALID; bit NUM_S is the default slave.
- arready_s  in  NUM_S+1  per-slave ARREADY.

Behaviour:
- Reset (rst low, async): all outputs 0; output register empty; rr_ptr=0; all outstanding counters=0; recorded slave indices=0.
- Eligible master k: arvalid_m[k]=1 and cnt[k]<MAX_OUT, using the pre-update counter value.
- Arbitration: round-robin over eligible masters, searching from rr_ptr upward with modulo NUM_M.
  - On grant to w, rr_ptr<=(w+1) mod NUM_M.
  - A single eligible master is granted regardless of rr_ptr.
- Register state EMPTY: arready_m[w]=1 combinationally for the winner only; the payload and decoded target are captured. Next state FULL.
- Register state FULL:
  - arvalid_s[tgt]=1; payload outputs are stable and held until arready_s[tgt]=1.
  - On that handshake, if an eligible winner exists in the same cycle it is captured and the register stays FULL (throughput 1/cycle). Otherwise the register goes EMPTY.
  - In FULL without a handshake, arready_m is all 0.
- Latency: master handshake at cycle t gives slave arvalid at t+1.
- Decode:
  - Slave i matches if (addr & SLV_MASK[i])==SLV_BASE[i]; the lowest matching i wins.
  - No match routes to the default slave (bit NUM_S).
  - Decode is done on the master address at capture time.
- Outstanding counters:
  - cnt[m] increments on a slave-side AR handshake whose arid_s upper bits equal m.
  - cnt[m] decrements on rdone_m[m].
  - Simultaneous increment and decrement leaves the count unchanged.
  - A decrement at 0 is ignored and the count saturates at 0.
- arvalid_s is one-hot or zero; no slave is ever offered a request that has not been captured.
- A master holding arvalid without ready is legal; its payload must remain stable (master's obligation, not checked).

Optional Feature:
- Macro AR_SAME_SLAVE_EN.
- Defined:
  - Each master records the target index of its last issued request.
  - While cnt[m]>0, a request from m decoding to a different target is ineligible. This prevents out-of-order R returns across slaves.
  - When cnt[m]==0 the restriction lifts.
- Undefined: no target restriction; eligibility depends only on valid and the counter.

Test Plan:
- After reset, M0 reads 0x0000_0100 (S0 base 0x0, mask 0xFFFF_0000): arready_m[0]=1 in cycle 0; arvalid_s=6'b000001 in cycle 1 with arid_s={0,ID}; arready_s[0]=1 in cycle 1 completes the transfer and cnt[0]=1.
- M0 and M1 valid continuously, all slaves ready: grants alternate M0,M1,M0,M1, one per cycle, with rr_ptr toggling.
- Address 0xDEAD_0000 matching no slave: arvalid_s[5]=1 (default slave).
- MAX_OUT=4, M1 issues 4 reads with no rdone: the 5th request sees arready_m[1]=0; one rdone_m[1] pulse lets it be granted the next cycle.
- Slave holds arready_s=0 for 3 cycles: arvalid_s and payload are stable for all 3 cycles and no arready_m is asserted; rdone and increment in the same cycle leave cnt unchanged.
- Reset asserted while FULL: arvalid_s=0 immediately and counters clear. With AR_SAME_SLAVE_EN, M0 with cnt=1 to S0 requesting S1 is blocked until rdone_m[0].

Source files
------------

// File: rtl/ar_xbar_router.sv
// rtl/ar_xbar_router.sv - AXI read-address crossbar: round-robin arbitration, address decode, outstanding-read limiting
//
// Optional feature macro: AR_SAME_SLAVE_EN
//   When defined, a master with reads outstanding may only issue to the target of its last issued request.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-low
//   arid_m     master ARID, master k in slice k          (NUM_M*ID_W)
//   araddr_m   master ARADDR                             (NUM_M*ADDR_W)
//   arlen_m    master ARLEN                              (NUM_M*LEN_W)
//   arsize_m   master ARSIZE                             (NUM_M*SIZE_W)
//   arburst_m  master ARBURST                            (NUM_M*2)
//   arvalid_m  master ARVALID                            (NUM_M)
//   arready_m  master ARREADY, winner only               (NUM_M)
//   rdone_m    RLAST handshake pulse per master          (NUM_M)
//   arid_s     {master index, ARID} to all slaves        (IDS_W)
//   araddr_s   shared slave ARADDR                       (ADDR_W)
//   arlen_s    shared slave ARLEN                        (LEN_W)
//   arsize_s   shared slave ARSIZE                       (SIZE_W)
//   arburst_s  shared slave ARBURST                      (2)
//   arvalid_s  per-slave ARVALID, bit NUM_S = default    (NUM_S+1)
//   arready_s  per-slave ARREADY, bit NUM_S = default    (NUM_S+1)

module ar_xbar_router #(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 5,
  parameter int ID_W   = 4,
  parameter int IDS_W  = ID_W + $clog2(NUM_M),
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3,
  parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000,
                                                 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {32'hC000_0000, 32'hF000_0000, 32'hF000_0000,
                                                 32'hFFFF_0000, 32'hFFFF_0000},
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_M*ID_W-1:0]    arid_m,
  input  logic [NUM_M*ADDR_W-1:0]  araddr_m,
  input  logic [NUM_M*LEN_W-1:0]   arlen_m,
  input  logic [NUM_M*SIZE_W-1:0]  arsize_m,
  input  logic [NUM_M*2-1:0]       arburst_m,
  input  logic [NUM_M-1:0]         arvalid_m,
  output logic [NUM_M-1:0]         arready_m,
  input  logic [NUM_M-1:0]         rdone_m,
  output logic [IDS_W-1:0]         arid_s,
  output logic [ADDR_W-1:0]        araddr_s,
  output logic [LEN_W-1:0]         arlen_s,
  output logic [SIZE_W-1:0]        arsize_s,
  output logic [1:0]               arburst_s,
  output logic [NUM_S:0]           arvalid_s,
  input  logic [NUM_S:0]           arready_s
);

  localparam int MI_W  = IDS_W - ID_W;
  localparam int TGT_W = $clog2(NUM_S + 1);
  // Eligibility looks at the pre-update count, so one request sitting in the
  // output register can push a master to MAX_OUT+1; size the counter for it.
  localparam int CNT_W = $clog2(MAX_OUT + 2);

  logic              full_q;
  logic [TGT_W-1:0]  tgt_q;
  logic [MI_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  cnt_q [NUM_M];
  logic [TGT_W-1:0]  dec_tgt [NUM_M];
  logic [NUM_M-1:0]  elig;
  logic [NUM_M-1:0]  cnt_inc;
  logic [NUM_M-1:0]  cnt_dec;
  logic              slv_hs;
  logic              accept;
  logic              gnt_vld;
  logic [MI_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   sel_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic [SIZE_W-1:0] sel_size;
  logic [1:0]        sel_burst;
`ifdef AR_SAME_SLAVE_EN
  logic [TGT_W-1:0]  last_tgt [NUM_M];
`endif

  // Lowest matching slave wins; no match falls through to the default slave.
  function automatic logic [TGT_W-1:0] decode(input logic [ADDR_W-1:0] addr);
    logic [TGT_W-1:0] t;
    t = TGT_W'(NUM_S);
    for (int i = NUM_S - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        t = TGT_W'(i);
      end
    end
    return t;
  endfunction

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_M; k++) begin
      dec_tgt[k] = decode(araddr_m[k*ADDR_W +: ADDR_W]);
      elig[k]    = arvalid_m[k] && (cnt_q[k] < CNT_W'(MAX_OUT));
`ifdef AR_SAME_SLAVE_EN
      // Keeps R returns in order: no switching targets while reads are in flight.
      if ((cnt_q[k] != '0) && (dec_tgt[k] != last_tgt[k])) begin
        elig[k] = 1'b0;
      end
`endif
    end
  end

  // Round-robin search starting at rr_ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!gnt_vld && elig[(int'(rr_ptr) + i) % NUM_M]) begin
        gnt_vld = 1'b1;
        gnt_idx = MI_W'((int'(rr_ptr) + i) % NUM_M);
      end
    end
  end

  // The register can take a new request when empty or when its current
  // request leaves this cycle; reset gates the master-side ready.
  assign slv_hs = full_q && arready_s[tgt_q];
  assign accept = rst && (!full_q || slv_hs);

  always_comb begin
    arready_m = '0;
    if (accept && gnt_vld) begin
      arready_m[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    arvalid_s = '0;
    if (full_q) begin
      arvalid_s[tgt_q] = 1'b1;
    end
  end

  always_comb begin
    sel_id    = arid_m[gnt_idx*ID_W +: ID_W];
    sel_addr  = araddr_m[gnt_idx*ADDR_W +: ADDR_W];
    sel_len   = arlen_m[gnt_idx*LEN_W +: LEN_W];
    sel_size  = arsize_m[gnt_idx*SIZE_W +: SIZE_W];
    sel_burst = arburst_m[gnt_idx*2 +: 2];
  end

  always_comb begin
    cnt_inc = '0;
    cnt_dec = '0;
    for (int k = 0; k < NUM_M; k++) begin
      cnt_inc[k] = slv_hs && (arid_s[IDS_W-1:ID_W] == MI_W'(k));
      cnt_dec[k] = rdone_m[k] && (cnt_q[k] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= 1'b0;
      tgt_q     <= '0;
      rr_ptr    <= '0;
      arid_s    <= '0;
      araddr_s  <= '0;
      arlen_s   <= '0;
      arsize_s  <= '0;
      arburst_s <= '0;
      for (int k = 0; k < NUM_M; k++) begin
        cnt_q[k] <= '0;
`ifdef AR_SAME_SLAVE_EN
        last_tgt[k] <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NUM_M; k++) begin
        if (cnt_inc[k] && !cnt_dec[k]) begin
          cnt_q[k] <= cnt_q[k] + 1'b1;
        end else if (!cnt_inc[k] && cnt_dec[k]) begin
          cnt_q[k] <= cnt_q[k] - 1'b1;
        end
      end
      if (accept && gnt_vld) begin
        full_q    <= 1'b1;
        tgt_q     <= dec_tgt[gnt_idx];
        arid_s    <= {gnt_idx, sel_id};
        araddr_s  <= sel_addr;
        arlen_s   <= sel_len;
        arsize_s  <= sel_size;
        arburst_s <= sel_burst;
        rr_ptr    <= (gnt_idx == MI_W'(NUM_M - 1)) ? '0 : gnt_idx + 1'b1;
`ifdef AR_SAME_SLAVE_EN
        last_tgt[gnt_idx] <= dec_tgt[gnt_idx];
`endif
      end else if (slv_hs) begin
        full_q <= 1'b0;
      end
    end
  end

endmodule
